instr_fetch: RTL and testbench
==============================

# instr_fetch

- Fetch front end of the reduced RISC-V core.
- Produces the instruction stream that the control unit decodes.
- Owns the program counter and issues word requests to a synchronous instruction memory with fixed one-cycle read latency.
- Buffers the returned instructions in a 2-entry FIFO and presents them to decode over a valid/ready handshake. Decode's branch decision (PCsrc plus branch target) redirects fetch and flushes all younger work.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- imem_req_o  output  1  read request this cycle
- imem_addr_o  output  ADDR_WIDTH  byte address of request (low 2 bits always 0)
- imem_rdata_i  input  INSTR_WIDTH  read data, valid exactly one cycle after the request
- redirect_i  input  1  branch taken (PCsrc); sampled only in a cycle with a decode handshake
- redirect_target_i  input  ADDR_WIDTH  branch target (PC + ImmOp)
- instr_valid_o  output  1  head-of-FIFO instruction valid
- instr_ready_i  input  1  decode accepts
- instr_o  output  INSTR_WIDTH  instruction to decode
- instr_pc_o  output  ADDR_WIDTH  PC of instr_o

## Operation
- State:
  - fetch_pc register
  - 2-entry FIFO of {instr, pc}, holding count 0..2
  - inflight flag: a request was issued last cycle
  - squash flag: discard the in-flight response
- pop = instr_valid_o & instr_ready_i.
- Issue rule: imem_req_o = (count + inflight - pop) < 2. On issue, imem_addr_o = fetch_pc and fetch_pc advances by 4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0).
- Response: in the cycle after an issue, imem_rdata_i is pushed with its request PC, unless squash is set. The credit rule guarantees the FIFO is never overrun.
- Redirect (redirect_i & pop):
  - The handshaking instruction completes normally; it is the branch.
  - The remaining FIFO entry is dropped.
  - Any response arriving next cycle is squashed.
  - fetch_pc is loaded with redirect_target_i with bits [1:0] forced to 0.
  - A request made in the redirect cycle is squashed.
- redirect_i without pop is ignored.
- When instr_valid_o=0, instr_o and instr_pc_o are driven 0.
- FIFO order is strict; no instruction is duplicated or skipped except via redirect.

## Timing
- During reset, all of the following are 0 immediately (asynchronous): imem_req_o, instr_valid_o, instr_o, instr_pc_o, count, inflight, squash. fetch_pc = RESET_PC.
- Cycle 0 = first edge after rst_n rises:
  - request RESET_PC in cycle 0
  - data in cycle 1
  - instr_valid_o in cycle 2
- Steady state with instr_ready_i held 1: one instruction per cycle.
- Redirect in cycle R:
  - target requested R+1
  - target instruction on instr_o at R+3
  - instr_valid_o is 0 in R+1 and R+2
- Back-to-back redirects: each one restarts the sequence above.
- Response arrival in the same cycle as a redirect: that response is discarded.
- Backpressure: with instr_ready_i=0, at most 2 instructions are outstanding plus buffered. imem_req_o then stays 0 until a pop.
- Reset asserted mid-operation: all in-flight and buffered state is lost; restart from RESET_PC.

## Structure
- Shared package core_pkg holds:
  - INSTR_WIDTH and ADDR_WIDTH defaults
  - RESET_PC
  - opcode constants OP_ITYPE = 7'b0010011 and OP_BRANCH = 7'b1100011, shared with the control unit and the bench
- Sub-module fetch_fifo: a 2-entry FIFO with synchronous flush, carrying {instr, pc}, with a count output. The credit logic, PC register and squash logic stay in instr_fetch.

## Test plan
- **Reset and streaming.** Reset, instr_ready_i=1, memory word at 0 = 0x00A00093. Required response:
  - requests to 0x0, 0x4, 0x8 in cycles 0, 1, 2
  - cycle 2: instr_o=0x00A00093, instr_pc_o=0
  - cycle 3: instr_pc_o=4
- **Backpressure.** Hold instr_ready_i=0 from cycle 0. Required response:
  - only addresses 0x0 and 0x4 are requested
  - imem_req_o stays 0 thereafter
  - on raising ready, PCs 0x0 and 0x4 are delivered in consecutive cycles, then 0x8 follows
- **Redirect.** redirect_i=1, target=0x40 on the pop of PC 0x8. Required response:
  - PCs 0xC and 0x10 never appear on instr_pc_o
  - imem_addr_o=0x40 at R+1
  - instr_pc_o=0x40 with instr_valid_o=1 at R+3
- **Misaligned target and ignored redirect.** Redirect target=0x43 fetches 0x40. redirect_i=1 with instr_ready_i=0 causes no flush.
- **PC wrap.** RESET_PC=0xFFFFFFF8 gives request sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- **Reset mid-operation.** Drop rst_n with 2 entries buffered. Required response:
  - instr_valid_o and imem_req_o go to 0 without a clock edge
  - after release, the first delivered PC is RESET_PC

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: widths, reset PC, opcode constants and fetch entry type shared by the core and its benches.
package core_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INSTR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory port, decode handshake and branch redirect of the fetch unit.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = core_pkg::INSTR_WIDTH
);
  logic imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [INSTR_WIDTH-1:0] imem_rdata_i;
  logic redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_target_i;
  logic instr_valid_o;
  logic instr_ready_i;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input imem_rdata_i, redirect_i, redirect_target_i, instr_ready_i
  );
  modport slave (
    input imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_rdata_i, redirect_i, redirect_target_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry in-order buffer of {instr, pc} with synchronous flush; entry 0 is always the head.
module fetch_fifo import core_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [1:0] count_o
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d, wr_idx;
  always_comb begin
    e0_d = pop_i ? e1_q : e0_q;
    e1_d = e1_q;
    wr_idx = count_q - {1'b0, pop_i};
    if (push_i && wr_idx == 2'd0) e0_d = data_i;
    if (push_i && wr_idx == 2'd1) e1_d = data_i;
    count_d = flush_i ? 2'd0 : count_q + {1'b0, push_i} - {1'b0, pop_i};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  assign head_o = e0_q;
  assign count_o = count_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, credit-based issue to a 1-cycle instruction memory, and redirect/squash handling.
module instr_fetch import core_pkg::*; #(
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_if.master bus
);
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, req_pc_q;
  logic inflight_q, squash_q;
  logic valid, pop, redir, req, push;
  logic [1:0] count;
  logic [2:0] occ;
  fetch_entry_t head;
  always_comb begin
    valid = count != 2'd0;
    pop = valid & bus.instr_ready_i;
    redir = pop & bus.redirect_i;
    occ = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    // Gated by rst_n so no request is visible while reset is held.
    req = rst_n & (occ < 3'd2);
    push = inflight_q & ~squash_q & ~redir;
    fetch_pc_d = redir ? word_align(bus.redirect_target_i)
               : req ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      inflight_q <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= fetch_pc_q;
      inflight_q <= req;
      squash_q <= redir;
    end
  end
  fetch_fifo u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(redir),
    .push_i(push),
    .pop_i(pop),
    .data_i('{instr: bus.imem_rdata_i, pc: req_pc_q}),
    .head_o(head),
    .count_o(count)
  );
  assign bus.imem_req_o = req;
  assign bus.imem_addr_o = req ? fetch_pc_q : '0;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o = valid ? head.instr : '0;
  assign bus.instr_pc_o = valid ? head.pc : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard of expected PC stream plus per-scenario cycle checks for instr_fetch.
module tb_instr_fetch;
  import core_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  always #5 clk = ~clk;
  instr_fetch_if bus ();
  instr_fetch_if bus2 ();
  instr_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a == 32'h0 ? 32'h00A00093 : {a[24:0], OP_ITYPE};
  endfunction
  function automatic void sb_load(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(a + 32'(4 * i));
  endfunction
  always @(posedge clk) if (bus.imem_req_o) bus.imem_rdata_i <= imem(bus.imem_addr_o);
  always @(posedge clk) if (bus2.imem_req_o) bus2.imem_rdata_i <= imem(bus2.imem_addr_o);
  always @(negedge clk) begin
    if (rst_n && bus.instr_valid_o && bus.instr_ready_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_stream: got pc %h, required no delivery", bus.instr_pc_o);
      end else begin
        sb_e = exp_q.pop_front();
        if (bus.instr_pc_o !== sb_e || bus.instr_o !== imem(sb_e)) begin
          n_fail++;
          $display("FAIL sb_stream: got pc %h instr %h, required pc %h instr %h",
                   bus.instr_pc_o, bus.instr_o, sb_e, imem(sb_e));
        end
      end
      if (bus.redirect_i) sb_load(bus.redirect_target_i & ~32'h3);
    end
  end
  task automatic tick(input logic r, input logic rd, input logic [31:0] t);
    @(posedge clk);
    #2;
    bus.instr_ready_i = r;
    bus.redirect_i = rd;
    bus.redirect_target_i = t;
    @(negedge clk);
  endtask
  task automatic do_reset(input logic r);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.instr_ready_i = r;
    bus.redirect_i = 1'b0;
    bus.redirect_target_i = '0;
    sb_load(32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset;
    #1;
    n_tests++;
    if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%b valid=%b, required 0/0", bus.imem_req_o, bus.instr_valid_o);
    end
    n_tests++;
    if (bus.instr_o !== 32'h0 || bus.instr_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: instr=%h pc=%h, required 0/0", bus.instr_o, bus.instr_pc_o);
    end
    n_tests++;
    if (bus2.imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req2: req=%b, required 0", bus2.imem_req_o);
    end
  endtask
  task automatic test_stream;
    do_reset(1'b1);
    n_tests++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL stream_c0: req=%b addr=%h, required 1/00000000", bus.imem_req_o, bus.imem_addr_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4) begin
      n_fail++;
      $display("FAIL stream_c1: req=%b addr=%h, required 1/00000004", bus.imem_req_o, bus.imem_addr_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.imem_addr_o !== 32'h8 || bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h00A00093 ||
        bus.instr_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL stream_c2: addr=%h valid=%b instr=%h pc=%h, required 8/1/00a00093/0",
               bus.imem_addr_o, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h4) begin
      n_fail++;
      $display("FAIL stream_c3: valid=%b pc=%h, required 1/4", bus.instr_valid_o, bus.instr_pc_o);
    end
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);
  endtask
  task automatic test_backpressure;
    int nreq = 0;
    do_reset(1'b0);
    tick(1'b0, 1'b0, '0);
    n_tests++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_c1: req=%b addr=%h, required 1/00000004", bus.imem_req_o, bus.imem_addr_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, '0);
      if (bus.imem_req_o !== 1'b0) nreq++;
    end
    n_tests++;
    if (nreq != 0) begin
      n_fail++;
      $display("FAIL bp_stall_req: %0d extra requests, required 0", nreq);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_pc_o !== 32'h0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin
      n_fail++;
      $display("FAIL bp_release: pc=%h req=%b addr=%h, required 0/1/8",
               bus.instr_pc_o, bus.imem_req_o, bus.imem_addr_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b pc=%h, required 1/4", bus.instr_valid_o, bus.instr_pc_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h8) begin
      n_fail++;
      $display("FAIL bp_third: valid=%b pc=%h, required 1/8", bus.instr_valid_o, bus.instr_pc_o);
    end
  endtask
  task automatic test_redirect;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h40);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h8) begin
      n_fail++;
      $display("FAIL redir_branch: valid=%b pc=%h, required 1/8", bus.instr_valid_o, bus.instr_pc_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h40) begin
      n_fail++;
      $display("FAIL redir_r1: valid=%b req=%b addr=%h, required 0/1/40",
               bus.instr_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_r2: valid=%b, required 0", bus.instr_valid_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h40) begin
      n_fail++;
      $display("FAIL redir_r3: valid=%b pc=%h, required 1/40", bus.instr_valid_o, bus.instr_pc_o);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, '0);
  endtask
  task automatic test_misaligned_ignored;
    do_reset(1'b1);
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 32'h80);
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL ignored_redir: valid=%b pc=%h, required 1/0", bus.instr_valid_o, bus.instr_pc_o);
    end
    tick(1'b1, 1'b1, 32'h43);
    n_tests++;
    if (bus.instr_pc_o !== 32'h4) begin
      n_fail++;
      $display("FAIL misalign_branch: pc=%h, required 4", bus.instr_pc_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h40) begin
      n_fail++;
      $display("FAIL misalign_addr: req=%b addr=%h, required 1/40", bus.imem_req_o, bus.imem_addr_o);
    end
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h40) begin
      n_fail++;
      $display("FAIL misalign_pc: valid=%b pc=%h, required 1/40", bus.instr_valid_o, bus.instr_pc_o);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
  endtask
  task automatic test_back_to_back;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h100);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 32'h200);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h100) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b pc=%h, required 1/100", bus.instr_valid_o, bus.instr_pc_o);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL b2b_r1: valid=%b addr=%h, required 0/200", bus.instr_valid_o, bus.imem_addr_o);
    end
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h200) begin
      n_fail++;
      $display("FAIL b2b_r3: valid=%b pc=%h, required 1/200", bus.instr_valid_o, bus.instr_pc_o);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
  endtask
  task automatic test_wrap;
    logic [31:0] seen [3];
    do_reset(1'b1);
    seen[0] = bus2.imem_addr_o;
    tick(1'b1, 1'b0, '0);
    seen[1] = bus2.imem_addr_o;
    tick(1'b1, 1'b0, '0);
    seen[2] = bus2.imem_addr_o;
    n_tests++;
    if (seen[0] !== 32'hFFFF_FFF8 || seen[1] !== 32'hFFFF_FFFC || seen[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h %h %h, required fffffff8 fffffffc 00000000", seen[0], seen[1], seen[2]);
    end
    n_tests++;
    if (bus2.instr_valid_o !== 1'b1 || bus2.instr_pc_o !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL wrap_pc: valid=%b pc=%h, required 1/fffffff8", bus2.instr_valid_o, bus2.instr_pc_o);
    end
  endtask
  task automatic test_reset_mid;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: valid=%b, required 1", bus.instr_valid_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.instr_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_async: valid=%b req=%b pc=%h, required 0/0/0",
               bus.instr_valid_o, bus.imem_req_o, bus.instr_pc_o);
    end
    sb_load(32'h0);
    bus.instr_ready_i = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_restart_req: req=%b addr=%h, required 1/0", bus.imem_req_o, bus.imem_addr_o);
    end
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_restart_pc: valid=%b pc=%h, required 1/0", bus.instr_valid_o, bus.instr_pc_o);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
  endtask
  initial begin
    bus.instr_ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_target_i = '0;
    bus2.instr_ready_i = 1'b1;
    bus2.redirect_i = 1'b0;
    bus2.redirect_target_i = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned_ignored();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
